mc_control_fsm: RTL and testbench

- Multicycle control unit for the ARM-subset processor.
- Decodes the instruction fields and sequences FETCH/DECODE/EXECUTE/WRITEBACK states.
- Drives the unconditional datapath selects.
- Produces the raw PCS, RegW, MemW, FlagW and NoWrite requests that the conditional-execution logic gates with CondEx. It is the producer end of that interface.

---
 rtl/mc_control_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the ARM-subset core: sequences fetch/decode/execute/writeback
// and raises the raw write requests that conditional execution later gates.
// Optional feature: define MCFSM_ILLEGAL_TRAP_EN to trap Op=11 into a HALT state.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 written on final wait cycle
// DECODE   | register read, PC+8 computed for branch/PC operands
// MEMADR   | compute load/store address (Rn + ExtImm)
// MEMRD    | read data memory, held MEM_WAIT extra cycles
// MEMWB    | write loaded word to Rd
// MEMWR    | write data memory
// EXECUTER | data-proc with register operand
// EXECUTEI | data-proc with immediate operand
// ALUWB    | write ALU result to Rd
// BRANCH   | PC <- PC+8 + offset
// HALT     | illegal opcode trap (MCFSM_ILLEGAL_TRAP_EN only)
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       Illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
`ifdef MCFSM_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_HALT     = 4'd10;
`endif

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cnt_done;

  logic [3:0] cmd;
  logic       i_bit;
  logic       s_bit;
  logic [1:0] alu_op;
  logic       is_add_sub;
  logic       is_cmp;
  logic       cmd_known;
  logic [1:0] dec_flagw;

  logic       regw_raw;
  logic       memw_raw;
  logic       branch_raw;
  logic       irwrite_raw;
  logic [1:0] flagw_raw;
  logic       nowrite_raw;
  logic       adr_src;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_ctrl;
`ifdef MCFSM_ILLEGAL_TRAP_EN
  logic       illegal_raw;
`endif

  assign cmd      = Funct[4:1];
  assign i_bit    = Funct[5];
  assign s_bit    = Funct[0];
  assign cnt_done = (cnt_q == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unrecognised commands still execute as ADD but must never touch the flags.
  always_comb begin
    alu_op     = 2'b00;
    is_add_sub = 1'b0;
    is_cmp     = 1'b0;
    cmd_known  = 1'b1;
    case (cmd)
      4'b0100: begin alu_op = 2'b00; is_add_sub = 1'b1; end
      4'b0010: begin alu_op = 2'b01; is_add_sub = 1'b1; end
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      4'b1010: begin alu_op = 2'b01; is_cmp = 1'b1; end
      default: cmd_known = 1'b0;
    endcase
    dec_flagw = cmd_known ? {s_bit, s_bit & (is_add_sub | is_cmp)} : 2'b00;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      S_FETCH: begin
        if (cnt_done) state_d = S_DECODE;
        else          cnt_d   = cnt_q + 4'd1;
      end
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
`ifdef MCFSM_ILLEGAL_TRAP_EN
          default: state_d = S_HALT;
`else
          default: state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (cnt_done) state_d = S_MEMWB;
        else          cnt_d   = cnt_q + 4'd1;
      end
      S_MEMWB,
      S_MEMWR,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
`ifdef MCFSM_ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    branch_raw  = 1'b0;
    irwrite_raw = 1'b0;
    flagw_raw   = 2'b00;
    nowrite_raw = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl    = 2'b00;
`ifdef MCFSM_ILLEGAL_TRAP_EN
    illegal_raw = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        irwrite_raw = cnt_done;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:   alu_src_b = 2'b01;
      S_MEMRD:    adr_src   = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        regw_raw   = 1'b1;
      end
      S_MEMWR: begin
        adr_src  = 1'b1;
        memw_raw = 1'b1;
      end
      S_EXECUTER,
      S_EXECUTEI: begin
        alu_src_b   = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_ctrl    = alu_op;
        flagw_raw   = dec_flagw;
        nowrite_raw = is_cmp;
      end
      // CMP keeps NoWrite up so the downstream gate suppresses this RegW.
      S_ALUWB: begin
        regw_raw    = 1'b1;
        nowrite_raw = is_cmp;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch_raw = 1'b1;
      end
`ifdef MCFSM_ILLEGAL_TRAP_EN
      S_HALT:     illegal_raw = 1'b1;
`endif
      default: ;
    endcase
  end

  // Write enables are masked while reset is held so nothing leaks out mid-reset.
  assign RegW       = regw_raw & ~reset;
  assign MemW       = memw_raw & ~reset;
  assign PCS        = (branch_raw | (regw_raw & (Rd == 4'hF))) & ~reset;
  assign FlagW      = reset ? 2'b00 : flagw_raw;
  assign IRWrite    = irwrite_raw & ~reset;
  assign NextPC     = irwrite_raw & ~reset;
  assign NoWrite    = nowrite_raw;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ALUControl = alu_ctrl;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
`ifdef MCFSM_ILLEGAL_TRAP_EN
  assign Illegal    = illegal_raw & ~reset;
`else
  assign Illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues per-cycle expected output vectors,
// a monitor pops and compares one per falling edge; mid-cycle probes go through the same monitor.
module tb_mc_control_fsm;
  localparam int MW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'h0;
  logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc, ALUSrcA, Illegal;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  mc_control_fsm #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NoWrite(NoWrite),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  logic [21:0] act;
  assign act = {PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Illegal};

  logic [21:0] exp_q[$];
  string       name_q[$];
  logic [21:0] prb_q[$];
  string       prbn_q[$];
  event        probe_ev;
  int          checks = 0;
  int          errors = 0;

  // ImmSrc/RegSrc follow the Op currently driven.
  function automatic logic [21:0] mk(input logic pcs, input logic regw, input logic memw,
                                     input logic [1:0] flagw, input logic nowr,
                                     input logic irw, input logic npc, input logic adr,
                                     input logic [1:0] res, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] aluc,
                                     input logic ill);
    return {pcs, regw, memw, flagw, nowr, irw, npc, adr, res, srca, srcb, aluc,
            Op, Op == 2'b01, Op == 2'b10, ill};
  endfunction

  task automatic push(input logic [21:0] v, input string n);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  task automatic probe(input logic [21:0] v, input string n);
    prb_q.push_back(v);
    prbn_q.push_back(n);
    -> probe_ev;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_fetch;
    for (int i = 0; i < MW; i++)
      push(mk(0,0,0,2'b00,0,0,0,0,2'b10,1,2'b10,2'b00,0), "fetch_wait");
    push(mk(0,0,0,2'b00,0,1,1,0,2'b10,1,2'b10,2'b00,0), "fetch_last");
    push(mk(0,0,0,2'b00,0,0,0,0,2'b10,1,2'b10,2'b00,0), "decode");
  endtask

  task automatic dp(input logic [5:0] f, input logic [3:0] rd, input logic [1:0] srcb,
                    input logic [1:0] aluc, input logic [1:0] flagw, input logic nowr,
                    input logic pcs);
    Op = 2'b00; Funct = f; Rd = rd;
    push_fetch();
    push(mk(0,0,0,flagw,nowr,0,0,0,2'b00,0,srcb,aluc,0), "execute");
    push(mk(pcs,1,0,2'b00,nowr,0,0,0,2'b00,0,2'b00,2'b00,0), "aluwb");
    run(MW + 4);
  endtask

  task automatic ldr(input logic [3:0] rd, input logic pcs);
    Op = 2'b01; Funct = 6'b011001; Rd = rd;
    push_fetch();
    push(mk(0,0,0,2'b00,0,0,0,0,2'b00,0,2'b01,2'b00,0), "memadr");
    for (int i = 0; i <= MW; i++)
      push(mk(0,0,0,2'b00,0,0,0,1,2'b00,0,2'b00,2'b00,0), "memrd");
    push(mk(pcs,1,0,2'b00,0,0,0,0,2'b01,0,2'b00,2'b00,0), "memwb");
    run(2 * MW + 5);
  endtask

  task automatic str_to_memwr;
    Op = 2'b01; Funct = 6'b011000; Rd = 4'h5;
    push_fetch();
    push(mk(0,0,0,2'b00,0,0,0,0,2'b00,0,2'b01,2'b00,0), "memadr");
    run(MW + 3);
  endtask

  task automatic br;
    Op = 2'b10; Funct = 6'b100000; Rd = 4'h0;
    push_fetch();
    push(mk(1,0,0,2'b00,0,0,0,0,2'b10,0,2'b01,2'b00,0), "branch");
    run(MW + 3);
  endtask

  initial begin
    logic [21:0] v;
    string n;
    forever begin
      @(negedge clk or probe_ev);
      while (prb_q.size() > 0) begin
        v = prb_q.pop_front();
        n = prbn_q.pop_front();
        checks++;
        if (n == "drain") begin
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
          end
        end else if (act !== v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, act, v);
        end
      end
      if (clk == 1'b0 && exp_q.size() > 0) begin
        v = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== v) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", n, act, v, $time);
        end
      end
    end
  end

  initial begin
    #7;
    probe(mk(0,0,0,2'b00,0,0,0,0,2'b10,1,2'b10,2'b00,0), "reset_hold");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    dp(6'b001000, 4'h1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);  // ADD R1,R2,R3
    dp(6'b110101, 4'h0, 2'b01, 2'b01, 2'b11, 1'b1, 1'b0);  // CMP imm
    dp(6'b000101, 4'hF, 2'b00, 2'b01, 2'b11, 1'b0, 1'b1);  // SUBS PC, reg
    dp(6'b100001, 4'h3, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0);  // ANDS imm
    dp(6'b011000, 4'h4, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);  // ORR reg
    dp(6'b000011, 4'h2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);  // EORS: unsupported
    dp(6'b101001, 4'hF, 2'b01, 2'b00, 2'b11, 1'b0, 1'b1);  // ADDS PC, imm
    ldr(4'hF, 1'b1);
    ldr(4'h4, 1'b0);

    str_to_memwr();
    Op = 2'b01; Funct = 6'b011000; Rd = 4'h5;
    push(mk(0,0,1,2'b00,0,0,0,1,2'b00,0,2'b00,2'b00,0), "memwr");
    run(1);
    br();

    Op = 2'b11; Funct = 6'b000000; Rd = 4'h0;
    push_fetch();
`ifdef MCFSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++)
      push(mk(0,0,0,2'b00,0,0,0,0,2'b00,0,2'b00,2'b00,1), "halt");
    run(MW + 2 + 20);
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
`else
    run(MW + 2);
`endif
    br();

    str_to_memwr();
    #1 probe(mk(0,0,1,2'b00,0,0,0,1,2'b00,0,2'b00,2'b00,0), "memwr_pre_reset");
    #1 reset = 1'b1;
    #1 probe(mk(0,0,0,2'b00,0,0,0,0,2'b10,1,2'b10,2'b00,0), "reset_in_memwr");
    @(posedge clk);
    #2 reset = 1'b0;
    br();
    dp(6'b001000, 4'h1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    probe(22'd0, "drain");
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
